int_multiply: RTL and testbench

- Sequential signed fixed-point multiplier: Q0.7 scale × Q9.8 value → Q9.8 product, saturated.
- Inverse of int_division: rescales a Q9.8 operand by a Q0.7 ratio, e.g. the FlashAttention output correction and a divider round-trip.
- Uses the same valid/ready handshake as int_division.
- Radix-2 shift-add datapath: one multiplier-bit per cycle, no DSP multiplier.

---
 rtl/aura_fixed_pkg.sv | 13 +
 rtl/int_multiply.sv | 68 ++++++
 tb/tb_int_multiply.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/aura_fixed_pkg.sv
// aura_fixed_pkg: shared Q0.7/Q9.8 fixed-point types, limits and saturation helper
package aura_fixed_pkg;
  typedef logic signed [7:0] q0_7_t;
  typedef logic signed [16:0] q9_8_t;
  localparam int Q98_FRAC = 8;
  localparam int Q07_FRAC = 7;
  localparam int Q98_MAX = 65535;
  localparam int Q98_MIN = -65536;
  typedef enum logic [1:0] {IDLE, CALC, DONE} mul_state_t;
  function automatic q9_8_t sat_q98(input logic signed [31:0] x);
    return (x > Q98_MAX) ? q9_8_t'(Q98_MAX) : (x < Q98_MIN) ? q9_8_t'(Q98_MIN) : q9_8_t'(x);
  endfunction
endpackage

// File: rtl/int_multiply.sv
// int_multiply: radix-2 shift-add signed Q0.7 x Q9.8 -> saturated Q9.8 multiplier
module int_multiply
  import aura_fixed_pkg::*;
#(
  parameter int VAL_W = 17,
  parameter int SCALE_W = 8,
  parameter int FRAC_SCALE = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld_in,
  output logic               rdy_out,
  output logic               vld_out,
  input  logic               rdy_in,
  input  logic [SCALE_W-1:0] scale_in,
  input  logic [VAL_W-1:0]   value_in,
  output logic [VAL_W-1:0]   product_out
);
  localparam int ACC_W = VAL_W + SCALE_W;
  localparam int CW = $clog2(SCALE_W);
  mul_state_t state, state_d;
  logic neg, last;
  logic [SCALE_W-1:0] sc_abs;
  logic [VAL_W-1:0] val_abs;
  logic [ACC_W-1:0] acc, acc_d;
  logic [CW-1:0] cnt;
  logic signed [31:0] wide;
  assign rdy_out = (state == IDLE) && !rst;
  always_comb begin
    acc_d = acc + (sc_abs[cnt] ? ACC_W'(ACC_W'(val_abs) << cnt) : ACC_W'(0));
    last = cnt == CW'(SCALE_W - 1);
    // magnitude is truncated before the sign is applied, so rounding is toward zero
    wide = neg ? -32'(acc_d >> FRAC_SCALE) : 32'(acc_d >> FRAC_SCALE);
    state_d = (state == IDLE) ? (vld_in ? CALC : IDLE) :
              (state == CALC) ? (last ? DONE : CALC) :
              (rdy_in ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vld_out <= 1'b0;
      product_out <= '0;
      acc <= '0;
      cnt <= '0;
      neg <= 1'b0;
      sc_abs <= '0;
      val_abs <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && vld_in) begin
        neg <= scale_in[SCALE_W-1] ^ value_in[VAL_W-1];
        sc_abs <= scale_in[SCALE_W-1] ? SCALE_W'(-scale_in) : scale_in;
        val_abs <= value_in[VAL_W-1] ? VAL_W'(-value_in) : value_in;
        acc <= '0;
        cnt <= '0;
      end
      if (state == CALC) begin
        acc <= acc_d;
        cnt <= cnt + 1'b1;
      end
      if (state == CALC && last) begin
        product_out <= VAL_W'(sat_q98(wide));
        vld_out <= 1'b1;
      end
      if (state == DONE && rdy_in) vld_out <= 1'b0;
    end
  end
endmodule

// File: tb/tb_int_multiply.sv
// tb_int_multiply: table-driven and scoreboard-checked bench for int_multiply
module tb_int_multiply;
  logic clk = 1'b0, rst = 1'b1, vld_in = 1'b0, rdy_in = 1'b0;
  logic rdy_out, vld_out;
  logic [7:0] scale_in = '0;
  logic [16:0] value_in = '0;
  logic [16:0] product_out;
  int checks = 0, failures = 0;
  logic [16:0] sb[$];
  typedef struct {
    logic signed [7:0] s;
    logic signed [16:0] v;
    logic signed [16:0] e;
  } vec_t;
  vec_t vecs[9];

  int_multiply dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_out(rdy_out), .vld_out(vld_out),
    .rdy_in(rdy_in), .scale_in(scale_in), .value_in(value_in), .product_out(product_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [16:0] model(input int s, input int v);
    int p;
    p = (s * v) / 128;
    p = (p > 65535) ? 65535 : (p < -65536) ? -65536 : p;
    return 17'(p);
  endfunction

  task automatic do_op(input logic signed [7:0] s, input logic signed [16:0] v,
                       input logic signed [16:0] e, input int hold);
    int n;
    logic [16:0] held, exp;
    n = 0;
    @(negedge clk);
    while (!rdy_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_before_accept", int'(rdy_out), 1);
    vld_in = 1'b1;
    scale_in = s;
    value_in = v;
    rdy_in = 1'b0;
    @(posedge clk);
    sb.push_back(e);
    #1;
    vld_in = 1'b0;
    scale_in = 8'($urandom);
    value_in = 17'($urandom);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      #1;
      if (vld_out) break;
      chk("rdy_out_busy", int'(rdy_out), 0);
    end
    chk("latency", n, 8);
    held = product_out;
    for (int i = 0; i < hold; i++) begin
      vld_in = 1'b1;
      scale_in = 8'($urandom);
      value_in = 17'($urandom);
      @(posedge clk);
      #1;
      chk("stall_vld", int'(vld_out), 1);
      chk("stall_rdy", int'(rdy_out), 0);
      chk("stall_hold", int'(product_out), int'(held));
    end
    vld_in = 1'b0;
    rdy_in = 1'b1;
    @(negedge clk);
    chk("vld_at_xfer", int'(vld_out), 1);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      chk("product", int'(signed'(product_out)), int'(signed'(exp)));
    end else chk("scoreboard_empty", 0, 1);
    @(posedge clk);
    #1;
    rdy_in = 1'b0;
    chk("vld_drop", int'(vld_out), 0);
    chk("idle_rdy", int'(rdy_out), 1);
  endtask

  initial begin
    logic signed [7:0] rs;
    logic signed [16:0] rv;
    vecs[0] = '{s: 8'sd64, v: 17'sd512, e: 17'sd256};
    vecs[1] = '{s: -8'sd128, v: 17'sd384, e: -17'sd384};
    vecs[2] = '{s: 8'sd127, v: 17'sd256, e: 17'sd254};
    vecs[3] = '{s: -8'sd128, v: -17'sd65536, e: 17'sd65535};
    vecs[4] = '{s: -8'sd128, v: 17'sd65535, e: -17'sd65535};
    vecs[5] = '{s: 8'sd100, v: -17'sd300, e: -17'sd234};
    vecs[6] = '{s: 8'sd3, v: -17'sd5, e: 17'sd0};
    vecs[7] = '{s: 8'sd0, v: 17'sd1234, e: 17'sd0};
    vecs[8] = '{s: 8'sd127, v: -17'sd65536, e: -17'sd65024};
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_vld", int'(vld_out), 0);
    chk("reset_product", int'(product_out), 0);
    chk("reset_rdy", int'(rdy_out), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("release_rdy", int'(rdy_out), 1);
    foreach (vecs[i]) do_op(vecs[i].s, vecs[i].v, vecs[i].e, 0);
    do_op(8'sd64, 17'sd1000, 17'sd500, 5);
    for (int i = 0; i < 16; i++) begin
      rs = 8'($urandom);
      rv = 17'($urandom);
      do_op(rs, rv, model(int'(rs), int'(rv)), i % 3);
    end
    do_op(8'sd127, 17'sd10000, 17'sd9921, 0);
    @(negedge clk);
    vld_in = 1'b1;
    scale_in = 8'sd5;
    value_in = 17'sd1000;
    @(posedge clk);
    #1;
    vld_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midop_rst_vld", int'(vld_out), 0);
    chk("midop_rst_product", int'(product_out), 0);
    chk("midop_rst_rdy", int'(rdy_out), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midop_release_rdy", int'(rdy_out), 1);
    repeat (10) @(posedge clk);
    #1;
    chk("dropped_no_vld", int'(vld_out), 0);
    do_op(8'sd32, 17'sd1024, 17'sd256, 0);
    do_op(8'sd64, 17'sd256, 17'sd128, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
